// File: rtl/uart_tx_if.sv
// Byte-in handshake and serial-out bundle for uart_tx.
// master drives the byte side (producer); slave is the transmitter itself.
interface uart_tx_if;
  // Handshake: a byte moves on a rising edge where i_Tx_DV && o_Tx_Ready. The
  // producer may hold i_Tx_DV high indefinitely. i_Tx_Byte is only looked at
  // on that edge. i_Tx_DV seen while o_Tx_Ready is low is dropped, not queued.
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;
  logic [2:0] o_State_Dbg;

  modport master (
    output i_Tx_DV,
    output i_Tx_Byte,
    input  o_Tx_Ready,
    input  o_Tx_Active,
    input  o_Tx_Serial,
    input  o_Tx_Done,
    input  o_State_Dbg
  );

  modport slave (
    input  i_Tx_DV,
    input  i_Tx_Byte,
    output o_Tx_Ready,
    output o_Tx_Active,
    output o_Tx_Serial,
    output o_Tx_Done,
    output o_State_Dbg
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit (11-bit frame); otherwise 10-bit frame.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 3
) (
  input logic     i_Clock,
  input logic     i_Rst_L,
  uart_tx_if.slave tx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] STOP_END = 8'(CLKS_PER_BIT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       serial_q, serial_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  logic accept;
  logic bit_end;

  assign accept  = tx.i_Tx_DV && (state_q == S_IDLE);
  assign bit_end = (cnt_q == BIT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    serial_d = 1'b1;
    active_d = 1'b0;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (accept) begin
          data_d  = tx.i_Tx_Byte;
          idx_d   = 3'd0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx.i_Tx_Byte;
`endif
        end
      end
      S_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        if (bit_end) begin
          cnt_d   = 8'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        serial_d = data_q[idx_q];
        active_d = 1'b1;
        if (bit_end) begin
          cnt_d = 8'd0;
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        serial_d = par_q;
        active_d = 1'b1;
        if (bit_end) begin
          cnt_d   = 8'd0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      S_STOP: begin
        // One cycle past the bit: the line register lags the state by a cycle,
        // so Ready/Done rise only once the stop bit has fully left the pin.
        if (cnt_q == STOP_END) begin
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          active_d = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 3'd0;
      data_q   <= 8'd0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign tx.o_Tx_Ready  = (state_q == S_IDLE);
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Done   = done_q;
  assign tx.o_State_Dbg = state_q;

endmodule
